// File: rtl/flop_ctrl_pkg.sv
// Shared types and constants for the flop control arbiter and related blocks.
// Holds the per-requester operation codes, the sequencer states and the recovery counter width.
package flop_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        LOAD  = 2'b01,
        CLEAR = 2'b10,
        SET   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EXEC  = 2'b01,
        RECOV = 2'b10
    } state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker: first valid bit at or above ptr, with wrap-around.
// Reusable by any arbiter that keeps its own pointer register.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    int pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = 0;
        for (int k = 0; k < N; k++) begin
            if (!any) begin
                pos = int'(ptr) + k;
                if (pos >= N) begin
                    pos = pos - N;
                end
                if (valid[pos]) begin
                    onehot[pos] = 1'b1;
                    idx         = IW'(pos);
                    any         = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/flop_ctrl_arbiter.sv
// Round-robin arbiter and control sequencer sharing one register bank between requesters.
// Converts the winning op into enable / sync-reset / sync-set strobes, then enforces recovery after CLEAR/SET.
module flop_ctrl_arbiter
    import flop_ctrl_pkg::*;
#(
    parameter int               NREQ      = 4,
    parameter int               WIDTH     = 8,
    parameter int               RECOV_CYC = 2,
    parameter logic [WIDTH-1:0] RST_VAL   = '0,
    localparam int              IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  C,
    input  logic                  R,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  bank_e,
    output logic                  bank_sr,
    output logic                  bank_ss,
    output logic [WIDTH-1:0]      bank_d,
    output logic [WIDTH-1:0]      bank_q,
    output logic [IDW-1:0]        gnt_id,
    output logic                  busy
);

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   bank_reg_q, bank_reg_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               e_q, e_d;
    logic               sr_q, sr_d;
    logic               ss_q, ss_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     gnt_id_q, gnt_id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0]    pick_onehot;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic               accept;

    rr_pick #(
        .N  (NREQ),
        .IW (IDW)
    ) u_pick (
        .valid  (req_valid),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Grants only exist while idle and out of reset; the handshake is valid & ready.
    assign accept    = (state_q == IDLE) && R && pick_any;
    assign req_ready = accept ? pick_onehot : '0;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        bank_reg_d = bank_reg_q;
        dout_d     = '0;
        e_d        = 1'b0;
        sr_d       = 1'b0;
        ss_d       = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        gnt_id_d   = gnt_id_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d     = op_t'(req_op[2*pick_idx +: 2]);
                    data_d   = req_data[WIDTH*pick_idx +: WIDTH];
                    gnt_id_d = pick_idx;
                    rr_ptr_d = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
                    state_d  = EXEC;
                    case (op_d)
                        LOAD: begin
                            e_d    = 1'b1;
                            dout_d = data_d;
                        end
                        CLEAR:   sr_d = 1'b1;
                        SET:     ss_d = 1'b1;
                        default: ;
                    endcase
                end
            end

            EXEC: begin
                case (op_q)
                    LOAD:    bank_reg_d = data_q;
                    CLEAR:   bank_reg_d = '0;
                    SET:     bank_reg_d = '1;
                    default: ;
                endcase
                if ((op_q == CLEAR || op_q == SET) && RECOV_CYC > 0) begin
                    state_d = RECOV;
                    cnt_d   = CNT_W'(RECOV_CYC);
                end else begin
                    state_d = IDLE;
                end
            end

            RECOV: begin
                // Leaving on the count of 1 gives exactly RECOV_CYC cycles here.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_q    <= IDLE;
            op_q       <= HOLD;
            data_q     <= '0;
            bank_reg_q <= RST_VAL;
            dout_q     <= '0;
            e_q        <= 1'b0;
            sr_q       <= 1'b0;
            ss_q       <= 1'b0;
            rr_ptr_q   <= '0;
            gnt_id_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            bank_reg_q <= bank_reg_d;
            dout_q     <= dout_d;
            e_q        <= e_d;
            sr_q       <= sr_d;
            ss_q       <= ss_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_id_q   <= gnt_id_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bank_e  = e_q;
    assign bank_sr = sr_q;
    assign bank_ss = ss_q;
    assign bank_d  = dout_q;
    assign bank_q  = bank_reg_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_flop_ctrl_arbiter.sv
// Randomized self-checking bench for flop_ctrl_arbiter against a cycle-count reference model.
// The model tracks remaining busy cycles and a pending op rather than FSM states.
module tb_flop_ctrl_arbiter;

    localparam int         NREQ      = 4;
    localparam int         WIDTH     = 8;
    localparam int         RECOV_CYC = 2;
    localparam logic [7:0] RST_VAL   = 8'h3C;

    logic                  C;
    logic                  R;
    logic [NREQ-1:0]       req_valid;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  bank_e, bank_sr, bank_ss;
    logic [WIDTH-1:0]      bank_d, bank_q;
    logic [1:0]            gnt_id;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_bank;
    int         m_ptr;
    int         m_gnt;
    int         m_busy_left;
    bit         m_exec;
    logic [1:0] m_op;
    logic [7:0] m_data;

    flop_ctrl_arbiter #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .RECOV_CYC (RECOV_CYC),
        .RST_VAL   (RST_VAL)
    ) dut (
        .C         (C),
        .R         (R),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_ready (req_ready),
        .bank_e    (bank_e),
        .bank_sr   (bank_sr),
        .bank_ss   (bank_ss),
        .bank_d    (bank_d),
        .bank_q    (bank_q),
        .gnt_id    (gnt_id),
        .busy      (busy)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_pick();
        int j;
        for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_bank      = RST_VAL;
        m_ptr       = 0;
        m_gnt       = 0;
        m_busy_left = 0;
        m_exec      = 1'b0;
        m_op        = 2'b00;
        m_data      = 8'h00;
    endtask

    task automatic check_all();
        int         w;
        logic [3:0] exp_ready;
        w = model_pick();
        exp_ready = (R && m_busy_left == 0 && w >= 0) ? (4'b0001 << w) : 4'b0000;
        check_output("req_ready", 32'(req_ready), 32'(exp_ready));
        check_output("bank_e",  32'(bank_e),  32'(m_exec && m_op == 2'b01));
        check_output("bank_sr", 32'(bank_sr), 32'(m_exec && m_op == 2'b10));
        check_output("bank_ss", 32'(bank_ss), 32'(m_exec && m_op == 2'b11));
        check_output("bank_d",  32'(bank_d),  32'((m_exec && m_op == 2'b01) ? m_data : 8'h00));
        check_output("bank_q",  32'(bank_q),  32'(m_bank));
        check_output("busy",    32'(busy),    32'(m_busy_left > 0));
        check_output("gnt_id",  32'(gnt_id),  32'(m_gnt));
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic step();
        int w;
        @(negedge C);
        check_all();
        w = (m_busy_left == 0) ? model_pick() : -1;
        @(posedge C);
        if (m_exec) begin
            case (m_op)
                2'b01:   m_bank = m_data;
                2'b10:   m_bank = 8'h00;
                2'b11:   m_bank = 8'hFF;
                default: ;
            endcase
        end
        if (m_busy_left > 0) m_busy_left--;
        m_exec = 1'b0;
        if (w >= 0) begin
            m_op        = req_op[2*w +: 2];
            m_data      = req_data[8*w +: 8];
            m_gnt       = w;
            m_ptr       = (w + 1) % NREQ;
            m_exec      = 1'b1;
            m_busy_left = 1 + ((m_op == 2'b10 || m_op == 2'b11) ? RECOV_CYC : 0);
        end
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_stimulus();
        req_valid = 4'($urandom);
        req_op    = 8'($urandom);
        req_data  = $urandom;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] d);
        req_valid[i]      = 1'b1;
        req_op[2*i +: 2]  = op;
        req_data[8*i +: 8] = d;
    endtask

    // Asserted between edges so the asynchronous path is exercised.
    task automatic do_reset(input int n);
        R = 1'b0;
        apply_stimulus();
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < n; i++) begin
            @(negedge C);
            apply_stimulus();
            #1;
            check_all();
            @(posedge C);
        end
        #1;
        R = 1'b1;
    endtask

    initial begin
        R         = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_data  = '0;
        model_reset();
        #2;
        do_reset(3);

        // Single LOAD from requester 2
        req_valid = '0;
        set_req(2, 2'b01, 8'hA5);
        step();
        req_valid = '0;
        step();
        check_output("load_bank_q", 32'(bank_q), 32'h A5);
        check_output("load_gnt_id", 32'(gnt_id), 32'd2);

        // All requesters loading continuously
        for (int i = 0; i < NREQ; i++) set_req(i, 2'b01, 8'(8'h10 + i));
        steps(12);

        // SET, then CLEAR with recovery competing against a LOAD
        req_valid = '0;
        set_req(0, 2'b11, 8'h00);
        step();
        req_valid = '0;
        steps(4);
        check_output("set_bank_q", 32'(bank_q), 32'h FF);
        set_req(1, 2'b10, 8'h00);
        set_req(3, 2'b01, 8'h5A);
        steps(3);
        req_valid[1] = 1'b0;
        steps(4);
        req_valid = '0;
        set_req(2, 2'b00, 8'h77);
        step();
        req_valid = '0;
        steps(2);

        // Reset while in recovery
        set_req(1, 2'b11, 8'h00);
        step();
        req_valid = '0;
        step();
        check_output("recov_busy", 32'(busy), 32'd1);
        do_reset(1);
        check_output("rst_bank_q", 32'(bank_q), 32'(RST_VAL));
        req_valid = '0;
        set_req(0, 2'b01, 8'h11);
        set_req(1, 2'b01, 8'h22);
        step();
        check_output("rst_prio_gnt", 32'(gnt_id), 32'd0);
        req_valid = '0;
        steps(2);

        // Random traffic with occasional mid-run reset
        for (int n = 0; n < 400; n++) begin
            apply_stimulus();
            if ($urandom_range(0, 59) == 0) begin
                do_reset($urandom_range(0, 2));
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
